// File: rtl/dsp19x2_lane_sequencer.sv
// Issue/collect sequencer for the DSP19x2 multiply-subtract accumulator: gathers a lane0/lane1
// operand pair, issues SEED then STEP beats, waits DSP_LATENCY clocks and returns both lane results.
module dsp19x2_lane_sequencer #(
  parameter int unsigned A_LANE_W    = 10,
  parameter int unsigned B_LANE_W    = 9,
  parameter int unsigned Z_LANE_W    = 19,
  parameter int unsigned DSP_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_lane,
  input  logic [A_LANE_W-1:0]   s_a,
  input  logic [B_LANE_W-1:0]   s_b,
  output logic [2*A_LANE_W-1:0] dsp_a,
  output logic [2*B_LANE_W-1:0] dsp_b,
  input  logic [2*Z_LANE_W-1:0] dsp_z,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_lane,
  output logic [Z_LANE_W-1:0]   m_data,
  output logic                  busy,
  output logic                  err
);

  localparam int unsigned CNT_W = 2;

  typedef enum logic [2:0] {
    S_IDLE, S_GET1, S_SEED, S_STEP, S_WAIT, S_OUT0, S_OUT1
  } state_t;

  state_t                  state_q, state_d;
  logic [A_LANE_W-1:0]     a0_q, a0_d, a1_q, a1_d;
  logic [B_LANE_W-1:0]     b0_q, b0_d, b1_q, b1_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [Z_LANE_W-1:0]     r1_q, r1_d;
  logic [2*A_LANE_W-1:0]   dsp_a_q, dsp_a_d;
  logic [2*B_LANE_W-1:0]   dsp_b_q, dsp_b_d;
  logic                    s_ready_q, s_ready_d;
  logic                    m_valid_q, m_valid_d;
  logic                    m_lane_q, m_lane_d;
  logic [Z_LANE_W-1:0]     m_data_q, m_data_d;
  logic                    busy_q, busy_d;
  logic                    err_q, err_d;
  logic                    s_fire;

  assign s_fire = s_valid && s_ready_q;

  // Next state; dsp_a/dsp_b are computed one beat early so the registered copies line up with SEED/STEP.
  always_comb begin
    state_d  = state_q;
    a0_d     = a0_q;
    a1_d     = a1_q;
    b0_d     = b0_q;
    b1_d     = b1_q;
    cnt_d    = cnt_q;
    r1_d     = r1_q;
    dsp_a_d  = '0;
    dsp_b_d  = '0;
    m_lane_d = m_lane_q;
    m_data_d = m_data_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        if (s_fire) begin
          if (!s_lane) begin
            a0_d    = s_a;
            b0_d    = s_b;
            state_d = S_GET1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_GET1: begin
        if (s_fire) begin
          if (s_lane) begin
            a1_d    = s_a;
            b1_d    = s_b;
            dsp_a_d = {s_a, a0_q};
            state_d = S_SEED;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_SEED: begin
        dsp_a_d = {a1_q, a0_q};
        dsp_b_d = {b1_q, b0_q};
        state_d = S_STEP;
      end
      S_STEP: begin
        cnt_d   = CNT_W'(DSP_LATENCY - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          m_data_d = dsp_z[Z_LANE_W-1:0];
          r1_d     = dsp_z[2*Z_LANE_W-1:Z_LANE_W];
          m_lane_d = 1'b0;
          state_d  = S_OUT0;
        end else begin
          cnt_d = CNT_W'(cnt_q - 1'b1);
        end
      end
      S_OUT0: begin
        if (m_ready) begin
          m_data_d = r1_q;
          m_lane_d = 1'b1;
          state_d  = S_OUT1;
        end
      end
      S_OUT1: begin
        if (m_ready) begin
          m_data_d = '0;
          m_lane_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    s_ready_d = (state_d == S_IDLE) || (state_d == S_GET1);
    m_valid_d = (state_d == S_OUT0) || (state_d == S_OUT1);
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      a0_q      <= '0;
      a1_q      <= '0;
      b0_q      <= '0;
      b1_q      <= '0;
      cnt_q     <= '0;
      r1_q      <= '0;
      dsp_a_q   <= '0;
      dsp_b_q   <= '0;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
      m_lane_q  <= 1'b0;
      m_data_q  <= '0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a0_q      <= a0_d;
      a1_q      <= a1_d;
      b0_q      <= b0_d;
      b1_q      <= b1_d;
      cnt_q     <= cnt_d;
      r1_q      <= r1_d;
      dsp_a_q   <= dsp_a_d;
      dsp_b_q   <= dsp_b_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      m_lane_q  <= m_lane_d;
      m_data_q  <= m_data_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign s_ready = s_ready_q;
  assign dsp_a   = dsp_a_q;
  assign dsp_b   = dsp_b_q;
  assign m_valid = m_valid_q;
  assign m_lane  = m_lane_q;
  assign m_data  = m_data_q;
  assign busy    = busy_q;
  assign err     = err_q;

endmodule

// File: tb/tb_dsp19x2_lane_sequencer.sv
// Bench for dsp19x2_lane_sequencer: two builds (latency 1 and 3), each driving a behavioural
// accumulator, with results checked against the closed-form per-lane formula.
module tb_dsp19x2_lane_sequencer;

  localparam int unsigned LAT0 = 1;
  localparam int unsigned LAT1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset   [2];
  logic        s_valid [2];
  logic        s_lane  [2];
  logic [9:0]  s_a     [2];
  logic [8:0]  s_b     [2];
  logic        m_ready [2];
  wire         s_ready [2];
  wire  [19:0] dsp_a   [2];
  wire  [17:0] dsp_b   [2];
  wire         m_valid [2];
  wire         m_lane  [2];
  wire  [18:0] m_data  [2];
  wire         busy    [2];
  wire         err     [2];

  int   n_checks = 0;
  int   n_fail   = 0;
  logic exp_err [2];

  // Accumulator: z_lane <= (a<<2) - z_lane[9:0]*b, mod 2^19
  function automatic logic [37:0] acc_next(input logic [19:0] a, input logic [17:0] b,
                                           input logic [37:0] z);
    logic [37:0] r;
    logic [18:0] zl;
    for (int i = 0; i < 2; i++) begin
      zl = z[19*i +: 19];
      r[19*i +: 19] = 19'({a[10*i +: 10], 2'b00}) - 19'(zl[9:0]) * 19'(b[9*i +: 9]);
    end
    return r;
  endfunction

  function automatic logic [18:0] ref_r(input int a, input int b);
    int p;
    p = a * 4;
    return 19'(p - (p % 1024) * b);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned L = (g == 0) ? LAT0 : LAT1;
    logic [37:0] st [L];

    always @(posedge clk) begin
      st[0] <= acc_next(dsp_a[g], dsp_b[g], st[0]);
      for (int k = 1; k < L; k++) st[k] <= st[k-1];
    end

    dsp19x2_lane_sequencer #(.DSP_LATENCY(L)) u_dut (
      .clk    (clk),
      .reset  (reset[g]),
      .s_valid(s_valid[g]),
      .s_ready(s_ready[g]),
      .s_lane (s_lane[g]),
      .s_a    (s_a[g]),
      .s_b    (s_b[g]),
      .dsp_a  (dsp_a[g]),
      .dsp_b  (dsp_b[g]),
      .dsp_z  (st[L-1]),
      .m_valid(m_valid[g]),
      .m_ready(m_ready[g]),
      .m_lane (m_lane[g]),
      .m_data (m_data[g]),
      .busy   (busy[g]),
      .err    (err[g])
    );
  end

  task automatic chk(input string tag, input logic [37:0] got, input logic [37:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input int i, input logic lane, input int a, input int b);
    int n;
    s_valid[i] = 1'b1;
    s_lane[i]  = lane;
    s_a[i]     = 10'(a);
    s_b[i]     = 9'(b);
    n = 0;
    while (!s_ready[i] && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) chk("s_ready_timeout", 38'd0, 38'd1);
    tick();
    s_valid[i] = 1'b0;
  endtask

  task automatic check_idle_outputs(input int i, input string tag);
    chk({tag, "_s_ready"}, 38'(s_ready[i]), 38'd1);
    chk({tag, "_dsp_a"},   38'(dsp_a[i]),   38'd0);
    chk({tag, "_dsp_b"},   38'(dsp_b[i]),   38'd0);
    chk({tag, "_m_valid"}, 38'(m_valid[i]), 38'd0);
    chk({tag, "_m_lane"},  38'(m_lane[i]),  38'd0);
    chk({tag, "_m_data"},  38'(m_data[i]),  38'd0);
    chk({tag, "_busy"},    38'(busy[i]),    38'd0);
    chk({tag, "_err"},     38'(err[i]),     38'd0);
  endtask

  task automatic run_op(input int i, input int a0, input int b0, input int a1, input int b1,
                        input int stall0, input int stall1, input bit bad_first, input bit bad_mid);
    int lat;
    int c;
    int ea;
    int eb;
    logic [18:0] exp_d;
    lat = (i == 0) ? int'(LAT0) : int'(LAT1);
    if (bad_first) begin
      send_beat(i, 1'b1, int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)));
      exp_err[i] = 1'b1;
      chk("bad_first_err", 38'(err[i]), 38'd1);
      chk("bad_first_idle", 38'(busy[i]), 38'd0);
    end
    send_beat(i, 1'b0, a0, b0);
    chk("get1_busy", 38'(busy[i]), 38'd1);
    if (bad_mid) begin
      send_beat(i, 1'b0, int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)));
      exp_err[i] = 1'b1;
      chk("bad_mid_err", 38'(err[i]), 38'd1);
      chk("bad_mid_ready", 38'(s_ready[i]), 38'd1);
    end
    repeat ($urandom_range(0, 2)) tick();
    send_beat(i, 1'b1, a1, b1);
    chk("seed_dsp_a", 38'(dsp_a[i]), 38'({10'(a1), 10'(a0)}));
    chk("seed_dsp_b", 38'(dsp_b[i]), 38'd0);
    chk("seed_s_ready", 38'(s_ready[i]), 38'd0);
    tick();
    chk("step_dsp_a", 38'(dsp_a[i]), 38'({10'(a1), 10'(a0)}));
    chk("step_dsp_b", 38'(dsp_b[i]), 38'({9'(b1), 9'(b0)}));
    tick();
    c = 2;
    chk("post_dsp_a", 38'(dsp_a[i]), 38'd0);
    chk("post_dsp_b", 38'(dsp_b[i]), 38'd0);
    chk("wait_busy", 38'(busy[i]), 38'd1);
    while (!m_valid[i] && c < 20) begin
      tick();
      c++;
    end
    chk("latency", 38'(c - 2), 38'(lat));
    for (int k = 0; k < 2; k++) begin
      ea    = (k == 0) ? a0 : a1;
      eb    = (k == 0) ? b0 : b1;
      exp_d = ref_r(ea, eb);
      chk("m_valid", 38'(m_valid[i]), 38'd1);
      chk("m_lane", 38'(m_lane[i]), 38'(k));
      chk("m_data", 38'(m_data[i]), 38'(exp_d));
      repeat ((k == 0) ? stall0 : stall1) begin
        tick();
        chk("hold_valid", 38'(m_valid[i]), 38'd1);
        chk("hold_lane", 38'(m_lane[i]), 38'(k));
        chk("hold_data", 38'(m_data[i]), 38'(exp_d));
      end
      m_ready[i] = 1'b1;
      tick();
      m_ready[i] = 1'b0;
    end
    chk("done_m_valid", 38'(m_valid[i]), 38'd0);
    chk("done_busy", 38'(busy[i]), 38'd0);
    chk("done_s_ready", 38'(s_ready[i]), 38'd1);
    chk("done_err", 38'(err[i]), 38'(exp_err[i]));
  endtask

  task automatic reset_mid_wait(input int i);
    send_beat(i, 1'b0, 7, 3);
    send_beat(i, 1'b1, 7, 3);
    tick();
    tick();
    chk("pre_reset_busy", 38'(busy[i]), 38'd1);
    reset[i] = 1'b1;
    tick();
    reset[i]   = 1'b0;
    exp_err[i] = 1'b0;
    check_idle_outputs(i, "mid_reset");
    repeat (6) begin
      tick();
      chk("no_valid_after_reset", 38'(m_valid[i]), 38'd0);
    end
    run_op(i, 7, 3, 7, 3, 0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      reset[i]   = 1'b1;
      s_valid[i] = 1'b0;
      s_lane[i]  = 1'b0;
      s_a[i]     = '0;
      s_b[i]     = '0;
      m_ready[i] = 1'b0;
      exp_err[i] = 1'b0;
    end
    tick();
    tick();
    for (int i = 0; i < 2; i++) check_idle_outputs(i, "reset");
    for (int i = 0; i < 2; i++) reset[i] = 1'b0;
    tick();

    for (int i = 0; i < 2; i++) begin
      run_op(i, 7, 3, 0, 0, 0, 0, 1'b0, 1'b0);
      run_op(i, 1023, 511, 5, 0, 0, 0, 1'b0, 1'b0);
      run_op(i, 7, 3, 0, 0, 5, 0, 1'b0, 1'b0);
      run_op(i, 7, 3, 0, 0, 0, 0, 1'b1, 1'b0);
      reset_mid_wait(i);
      repeat (30) begin
        run_op(i, int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)),
               int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
        repeat ($urandom_range(0, 2)) tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
